// File: rtl/pep_mmacc_gram_feed_arbiter.sv
// Per-bank round-robin arbiter for GRAM read bursts between the main and subs feeds.
// Optional grant/conflict statistics are enabled with PEP_MMACC_GARB_STAT_EN.
module pep_mmacc_gram_feed_arbiter #(
  parameter int GRAM_NB   = 4,
  parameter int GRAM_ID_W = $clog2(GRAM_NB),
  parameter int LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 s_rst,
  input  logic [GRAM_ID_W-1:0] main_req_gid,
  input  logic [LEN_W-1:0]     main_req_len,
  input  logic                 main_req_vld,
  output logic                 main_req_rdy,
  input  logic [GRAM_ID_W-1:0] subs_req_gid,
  input  logic [LEN_W-1:0]     subs_req_len,
  input  logic                 subs_req_vld,
  output logic                 subs_req_rdy,
  output logic [GRAM_NB-1:0]   main_rot_avail_1h,
  output logic [GRAM_NB-1:0]   main_dat_avail_1h,
  output logic [GRAM_NB-1:0]   subs_rot_avail_1h,
  output logic [GRAM_NB-1:0]   subs_dat_avail_1h,
  output logic [GRAM_NB-1:0]   gram_busy_1h
`ifdef PEP_MMACC_GARB_STAT_EN
  ,
  output logic [31:0]          stat_main_grant_cnt,
  output logic [31:0]          stat_subs_grant_cnt,
  output logic [31:0]          stat_conflict_cnt
`endif
);

  // owner/prio encoding: 0 = main, 1 = subs
  logic [GRAM_NB-1:0][LEN_W-1:0] rem_q, rem_d;
  logic [GRAM_NB-1:0]            owner_q, owner_d;
  logic [GRAM_NB-1:0]            prio_q, prio_d;
  logic [GRAM_NB-1:0]            main_rot_q, main_rot_d;
  logic [GRAM_NB-1:0]            subs_rot_q, subs_rot_d;
  logic [GRAM_NB-1:0]            busy;
  logic                          main_free, subs_free, same_bank;

  always_comb begin
    main_free = (rem_q[main_req_gid] <= LEN_W'(1));
    subs_free = (rem_q[subs_req_gid] <= LEN_W'(1));
    same_bank = main_req_vld & subs_req_vld & (main_req_gid == subs_req_gid);
    main_req_rdy = ~s_rst & main_req_vld & main_free & ~(same_bank & prio_q[main_req_gid]);
    subs_req_rdy = ~s_rst & subs_req_vld & subs_free & ~(same_bank & ~prio_q[subs_req_gid]);
  end

  always_comb begin
    owner_d    = owner_q;
    prio_d     = prio_q;
    main_rot_d = '0;
    subs_rot_d = '0;
    for (int g = 0; g < GRAM_NB; g++) begin
      busy[g]  = (rem_q[g] != '0);
      rem_d[g] = busy[g] ? rem_q[g] - LEN_W'(1) : '0;
    end
    // A granted conflict hands the next turn on that bank to the loser.
    if (same_bank && (main_req_rdy || subs_req_rdy)) begin
      prio_d[main_req_gid] = main_req_rdy;
    end
    if (main_req_rdy && (main_req_len != '0)) begin
      rem_d[main_req_gid]      = main_req_len;
      owner_d[main_req_gid]    = 1'b0;
      main_rot_d[main_req_gid] = 1'b1;
    end
    if (subs_req_rdy && (subs_req_len != '0)) begin
      rem_d[subs_req_gid]      = subs_req_len;
      owner_d[subs_req_gid]    = 1'b1;
      subs_rot_d[subs_req_gid] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      rem_q      <= '0;
      owner_q    <= '0;
      prio_q     <= '0;
      main_rot_q <= '0;
      subs_rot_q <= '0;
    end else begin
      rem_q      <= rem_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      main_rot_q <= main_rot_d;
      subs_rot_q <= subs_rot_d;
    end
  end

  always_comb begin
    main_rot_avail_1h = main_rot_q & {GRAM_NB{~s_rst}};
    subs_rot_avail_1h = subs_rot_q & {GRAM_NB{~s_rst}};
    main_dat_avail_1h = busy & ~owner_q & {GRAM_NB{~s_rst}};
    subs_dat_avail_1h = busy & owner_q & {GRAM_NB{~s_rst}};
    gram_busy_1h      = busy & {GRAM_NB{~s_rst}};
  end

`ifdef PEP_MMACC_GARB_STAT_EN
  logic [31:0] main_cnt_q, main_cnt_d;
  logic [31:0] subs_cnt_q, subs_cnt_d;
  logic [31:0] conf_cnt_q, conf_cnt_d;
  logic        refused;

  always_comb begin
    refused    = (main_req_vld & ~main_req_rdy) | (subs_req_vld & ~subs_req_rdy);
    main_cnt_d = main_cnt_q;
    subs_cnt_d = subs_cnt_q;
    conf_cnt_d = conf_cnt_q;
    if (main_req_rdy && (main_cnt_q != '1)) main_cnt_d = main_cnt_q + 32'd1;
    if (subs_req_rdy && (subs_cnt_q != '1)) subs_cnt_d = subs_cnt_q + 32'd1;
    if (refused && (conf_cnt_q != '1))      conf_cnt_d = conf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      main_cnt_q <= '0;
      subs_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      main_cnt_q <= main_cnt_d;
      subs_cnt_q <= subs_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign stat_main_grant_cnt = main_cnt_q;
  assign stat_subs_grant_cnt = subs_cnt_q;
  assign stat_conflict_cnt   = conf_cnt_q;
`endif

endmodule

// File: tb/tb_pep_mmacc_gram_feed_arbiter.sv
// Scoreboard bench: a timestamp-based bank reservation model predicts every cycle's outputs.
module tb_pep_mmacc_gram_feed_arbiter;
  localparam int NB  = 4;
  localparam int IDW = 2;
  localparam int LW  = 8;

  logic           clk = 1'b1;
  logic           s_rst = 1'b1;
  logic [IDW-1:0] main_req_gid = '0, subs_req_gid = '0;
  logic [LW-1:0]  main_req_len = '0, subs_req_len = '0;
  logic           main_req_vld = 1'b0, subs_req_vld = 1'b0;
  logic           main_req_rdy, subs_req_rdy;
  logic [NB-1:0]  main_rot_avail_1h, main_dat_avail_1h;
  logic [NB-1:0]  subs_rot_avail_1h, subs_dat_avail_1h, gram_busy_1h;

  pep_mmacc_gram_feed_arbiter #(.GRAM_NB(NB), .GRAM_ID_W(IDW), .LEN_W(LW)) dut (
    .clk               (clk),
    .s_rst             (s_rst),
    .main_req_gid      (main_req_gid),
    .main_req_len      (main_req_len),
    .main_req_vld      (main_req_vld),
    .main_req_rdy      (main_req_rdy),
    .subs_req_gid      (subs_req_gid),
    .subs_req_len      (subs_req_len),
    .subs_req_vld      (subs_req_vld),
    .subs_req_rdy      (subs_req_rdy),
    .main_rot_avail_1h (main_rot_avail_1h),
    .main_dat_avail_1h (main_dat_avail_1h),
    .subs_rot_avail_1h (subs_rot_avail_1h),
    .subs_dat_avail_1h (subs_dat_avail_1h),
    .gram_busy_1h      (gram_busy_1h)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mrdy;
    logic          srdy;
    logic [NB-1:0] mrot;
    logic [NB-1:0] mdat;
    logic [NB-1:0] srot;
    logic [NB-1:0] sdat;
    logic [NB-1:0] busy;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_f;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  // Model: each bank is reserved over cycles [start, hold]; free from cycle hold onward.
  int     start_c[NB];
  int     hold_c[NB];
  bit     own[NB];
  bit     subs_turn[NB];

  function automatic void model_reset();
    for (int g = 0; g < NB; g++) begin
      start_c[g] = -1; hold_c[g] = -1; own[g] = 1'b0; subs_turn[g] = 1'b0;
    end
  endfunction

  function automatic void cmp(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_f = exp_q.pop_front();
      cmp("main_rdy", 32'(main_req_rdy), 32'(mon_f.mrdy));
      cmp("subs_rdy", 32'(subs_req_rdy), 32'(mon_f.srdy));
      cmp("main_rot", 32'(main_rot_avail_1h), 32'(mon_f.mrot));
      cmp("main_dat", 32'(main_dat_avail_1h), 32'(mon_f.mdat));
      cmp("subs_rot", 32'(subs_rot_avail_1h), 32'(mon_f.srot));
      cmp("subs_dat", 32'(subs_dat_avail_1h), 32'(mon_f.sdat));
      cmp("busy", 32'(gram_busy_1h), 32'(mon_f.busy));
      cmp("dat_overlap", 32'(main_dat_avail_1h & subs_dat_avail_1h), 32'd0);
    end
  end

  task automatic step(input bit rst);
    frame_t f;
    bit     conf;
    int     mg, sg;
    s_rst = rst;
    f = '0;
    mg = int'(main_req_gid);
    sg = int'(subs_req_gid);
    conf = main_req_vld && subs_req_vld && (mg == sg);
    if (!rst) begin
      for (int g = 0; g < NB; g++) begin
        f.busy[g] = (cyc <= hold_c[g]);
        if (cyc >= start_c[g] && cyc <= hold_c[g]) begin
          if (own[g]) f.sdat[g] = 1'b1; else f.mdat[g] = 1'b1;
        end
        if (start_c[g] == cyc) begin
          if (own[g]) f.srot[g] = 1'b1; else f.mrot[g] = 1'b1;
        end
      end
      f.mrdy = main_req_vld && (cyc >= hold_c[mg]) && !(conf && subs_turn[mg]);
      f.srdy = subs_req_vld && (cyc >= hold_c[sg]) && !(conf && !subs_turn[sg]);
    end
    exp_q.push_back(f);
    if (rst) begin
      model_reset();
    end else begin
      if (conf && (f.mrdy || f.srdy)) subs_turn[mg] = f.mrdy;
      if (f.mrdy && main_req_len != 0) begin
        start_c[mg] = cyc + 1; hold_c[mg] = cyc + int'(main_req_len); own[mg] = 1'b0;
      end
      if (f.srdy && subs_req_len != 0) begin
        start_c[sg] = cyc + 1; hold_c[sg] = cyc + int'(subs_req_len); own[sg] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst || f.mrdy) main_req_vld = 1'b0;
    if (rst || f.srdy) subs_req_vld = 1'b0;
  endtask

  task automatic set_main(input int g, input int l);
    main_req_gid = IDW'(g); main_req_len = LW'(l); main_req_vld = 1'b1;
  endtask

  task automatic set_subs(input int g, input int l);
    subs_req_gid = IDW'(g); subs_req_len = LW'(l); subs_req_vld = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) step(1'b1);
    idle(2);
    // disjoint banks
    set_main(0, 3); set_subs(2, 2);
    idle(5);
    // same-bank conflict
    set_main(1, 4); set_subs(1, 4);
    idle(9);
    // round-robin on bank 3
    for (int i = 0; i < 4; i++) begin
      if (!main_req_vld) set_main(3, 1);
      if (!subs_req_vld) set_subs(3, 1);
      step(1'b0);
    end
    idle(4);
    // zero-length request
    set_main(0, 0);
    idle(3);
    // reset mid-burst, then immediate re-grant
    set_main(2, 10);
    idle(4);
    step(1'b1);
    set_main(0, 2);
    idle(4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!main_req_vld && ($urandom % 3 != 0))
        set_main(int'($urandom % NB),
                 ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, ($urandom % 5 == 0) ? 40 : 4)));
      if (!subs_req_vld && ($urandom % 3 != 0))
        set_subs(int'($urandom % NB),
                 ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, ($urandom % 5 == 0) ? 40 : 4)));
      step(($urandom % 300) == 0);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
